// File: rtl/mp3_bit_reader.sv
// Pulls N single bits (1..MAX_LEN) from the bit-reservoir FIFO and assembles them MSB-first.
// Optional CRC-16 over every received bit when MP3_BIT_READER_CRC_EN is defined.
module mp3_bit_reader #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               req_valid,
  input  logic [LEN_W-1:0]   req_len,
  output logic               req_ready,
  output logic               fifo_rd_en,
  input  logic               fifo_dout,
  input  logic               fifo_dvalid,
  input  logic [15:0]        fifo_dcount,
  output logic [MAX_LEN-1:0] field_out,
  output logic               field_valid,
  output logic [31:0]        bits_consumed
`ifdef MP3_BIT_READER_CRC_EN
  ,
  input  logic               crc_clr,
  output logic [15:0]        crc_out
`endif
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, issued_q, received_q, req_len_clamped;
  logic [MAX_LEN-1:0] shift_q, shift_nxt;
  logic               accept, bit_in, last_bit;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) > MAX_LEN) return CNT_W'(MAX_LEN);
    return CNT_W'(l);
  endfunction

  assign req_len_clamped = clamp_len(req_len);

  always_ff @(posedge clk) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The FIFO count is registered, so gating each strobe on dcount>0 can never over-read.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    fifo_rd_en  = 1'b0;
    field_valid = 1'b0;
    accept      = 1'b0;
    bit_in      = 1'b0;
    last_bit    = 1'b0;
    shift_nxt   = {shift_q[MAX_LEN-2:0], fifo_dout};
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_len_clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        fifo_rd_en = !srst && (issued_q < len_q) && (fifo_dcount != '0);
        bit_in     = fifo_dvalid;
        if (fifo_dvalid && (received_q + CNT_W'(1) == len_q)) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        field_valid = !srst;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // field_out is loaded on entry to DONE so it is already valid during the field_valid pulse.
  always_ff @(posedge clk) begin
    if (srst) begin
      len_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      shift_q       <= '0;
      field_out     <= '0;
      bits_consumed <= '0;
    end else begin
      if (accept) begin
        len_q      <= req_len_clamped;
        issued_q   <= '0;
        received_q <= '0;
        shift_q    <= '0;
        if (req_len_clamped == '0) field_out <= '0;
      end
      if (fifo_rd_en) issued_q <= issued_q + CNT_W'(1);
      if (bit_in) begin
        shift_q       <= shift_nxt;
        received_q    <= received_q + CNT_W'(1);
        bits_consumed <= bits_consumed + 32'd1;
      end
      if (last_bit) field_out <= shift_nxt;
    end
  end

`ifdef MP3_BIT_READER_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    if (c[15] ^ b) return {c[14:0], 1'b0} ^ 16'h8005;
    return {c[14:0], 1'b0};
  endfunction

  // A clear in the same cycle as an arriving bit folds that bit into the fresh seed.
  always_ff @(posedge clk) begin
    if (srst)        crc_q <= 16'hFFFF;
    else if (bit_in) crc_q <= crc_step(crc_clr ? 16'hFFFF : crc_q, fifo_dout);
    else if (crc_clr) crc_q <= 16'hFFFF;
  end

  assign crc_out = crc_q;
`endif

endmodule

// File: tb/tb_mp3_bit_reader.sv
// Bench for mp3_bit_reader: FIFO model, vector table, corner sequences and randomized requests.
// Builds with or without MP3_BIT_READER_CRC_EN.
module tb_mp3_bit_reader;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_len = '0;
  logic        req_ready;
  logic        fifo_rd_en;
  logic        fifo_dout = 1'b0;
  logic        fifo_dvalid = 1'b0;
  logic [15:0] fifo_dcount = '0;
  logic [31:0] field_out;
  logic        field_valid;
  logic [31:0] bits_consumed;
`ifdef MP3_BIT_READER_CRC_EN
  logic        crc_clr = 1'b0;
  logic [15:0] crc_out;
`endif

  mp3_bit_reader #(.MAX_LEN(32), .LEN_W(6)) dut (
    .clk(clk), .srst(srst), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_dvalid(fifo_dvalid), .fifo_dcount(fifo_dcount), .field_out(field_out),
    .field_valid(field_valid), .bits_consumed(bits_consumed)
`ifdef MP3_BIT_READER_CRC_EN
    , .crc_clr(crc_clr), .crc_out(crc_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit fq[$];
  bit ref_q[$];
  int rd_cnt = 0;
  int overread = 0;
  logic inj_dv = 1'b0;
  logic [31:0] total_bits = '0;

  // One-bit-wide FIFO with one-cycle read latency and a registered count.
  always @(posedge clk) begin
    fifo_dvalid <= inj_dv;
    if (inj_dv) fifo_dout <= 1'($urandom);
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fq.size() > 0) begin
        fifo_dout   <= fq.pop_front();
        fifo_dvalid <= 1'b1;
      end else begin
        overread <= overread + 1;
      end
    end
    fifo_dcount <= 16'(fq.size());
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      fq.push_back(b[i]);
      ref_q.push_back(b[i]);
    end
  endtask

  task automatic flush();
    fq.delete();
    ref_q.delete();
  endtask

  // Expected field: the next n bits of the written stream, first bit most significant.
  task automatic take_ref(input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++)
      if (ref_q.size() > 0) v = {v[30:0], 1'(ref_q.pop_front())};
    total_bits = total_bits + 32'(n);
  endtask

`ifdef MP3_BIT_READER_CRC_EN
  function automatic logic [15:0] crc_gold(input logic [7:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 7; i >= 0; i--)
      c = (c[15] ^ b[i]) ? ((c << 1) ^ 16'h8005) : (c << 1);
    return c;
  endfunction
`endif

  task automatic run_req(input int len, input bit rnd, output logic [31:0] fld,
                         output logic [31:0] expv, output int lat, output int strobes);
    int r0, n;
    n = (len > 32) ? 32 : len;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("field_valid_idle", 32'(field_valid), 32'd0);
    r0 = rd_cnt;
    req_valid = 1'b1;
    req_len = 6'(len);
    lat = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rnd && $urandom_range(0, 2) == 0) push_byte(8'($urandom));
      if (field_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) timeout_fail("field_valid_wait");
    fld = field_out;
    strobes = rd_cnt - r0;
    take_ref(n, expv);
    chk("bits_consumed", bits_consumed, total_bits);
    chk("req_ready_done", 32'(req_ready), 32'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    int          nbytes;
    int          len;
    logic [31:0] exp;
    bit          do_flush;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [31:0] fld, expv;
    int lat, strobes, r0, n, cnt;
    bit ok;

    vt[0] = '{32'h000000A5, 1, 8,  32'h000000A5, 1'b1};
    vt[1] = '{32'h12345678, 4, 4,  32'h00000001, 1'b1};
    vt[2] = '{32'h00000000, 0, 12, 32'h00000234, 1'b0};
    vt[3] = '{32'h00000000, 0, 16, 32'h00005678, 1'b0};
    vt[4] = '{32'hDEADBEEF, 4, 40, 32'hDEADBEEF, 1'b1};
    vt[5] = '{32'h000000C3, 1, 1,  32'h00000001, 1'b1};
    vt[6] = '{32'h89ABCDEF, 4, 32, 32'h89ABCDEF, 1'b1};
    vt[7] = '{32'h00000000, 0, 0,  32'h00000000, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_field_out", field_out, 32'd0);
    chk("rst_field_valid", 32'(field_valid), 32'd0);
    chk("rst_bits_consumed", bits_consumed, 32'd0);

    // Stray FIFO valids while idle are ignored
    inj_dv = 1'b1;
    repeat (4) @(negedge clk);
    inj_dv = 1'b0;
    @(negedge clk);
    chk("idle_dvalid_ignored", bits_consumed, 32'd0);

    // Table of preloaded fields
    for (int v = 0; v < 8; v++) begin
      if (vt[v].do_flush) flush();
      for (int b = vt[v].nbytes - 1; b >= 0; b--) push_byte(vt[v].data[b*8 +: 8]);
      n = (vt[v].len > 32) ? 32 : vt[v].len;
      run_req(vt[v].len, 1'b0, fld, expv, lat, strobes);
      chk($sformatf("vec%0d_field", v), fld, vt[v].exp);
      chk($sformatf("vec%0d_latency", v), 32'(lat), (n == 0) ? 32'd1 : 32'(n + 2));
      chk($sformatf("vec%0d_strobes", v), 32'(strobes), 32'(n));
    end

    // Empty FIFO stall: no strobes until data arrives
    flush();
    @(negedge clk);
    r0 = rd_cnt;
    req_valid = 1'b1;
    req_len = 6'd3;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (fifo_rd_en) cnt++;
    end
    chk("stall_no_rd_en", 32'(cnt), 32'd0);
    push_byte(8'hE0);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (field_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) timeout_fail("stall_field_valid");
    chk("stall_field", field_out, 32'h7);
    chk("stall_strobes", 32'(rd_cnt - r0), 32'd3);
    chk("stall_fifo_left", 32'(fq.size()), 32'd5);
    take_ref(3, expv);
    chk("stall_bits_consumed", bits_consumed, total_bits);

    // Reset mid-FETCH after five strobes
    flush();
    push_byte(8'hAB);
    push_byte(8'hCD);
    @(negedge clk);
    r0 = rd_cnt;
    req_valid = 1'b1;
    req_len = 6'd16;
    ok = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rd_cnt - r0 >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("mid_fetch_strobes");
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("srst_req_ready", 32'(req_ready), 32'd1);
    chk("srst_bits_consumed", bits_consumed, 32'd0);
    chk("srst_field_out", field_out, 32'd0);
    chk("srst_rd_en", 32'(fifo_rd_en), 32'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (field_valid) cnt++;
    end
    chk("srst_no_field_valid", 32'(cnt), 32'd0);
    chk("srst_strobes", 32'(rd_cnt - r0), 32'd5);
    chk("srst_fifo_left", 32'(fq.size()), 32'd11);
    flush();
    total_bits = '0;

    // Randomized requests against the stream model
    for (int i = 0; i < 25; i++) begin
      run_req(int'($urandom_range(0, 40)), 1'b1, fld, expv, lat, strobes);
      chk($sformatf("rand%0d_field", i), fld, expv);
    end
    chk("no_overread", 32'(overread), 32'd0);

`ifdef MP3_BIT_READER_CRC_EN
    // CRC of a single 0x00 byte after a clear
    flush();
    push_byte(8'h00);
    @(negedge clk);
    crc_clr = 1'b1;
    @(negedge clk);
    crc_clr = 1'b0;
    run_req(8, 1'b0, fld, expv, lat, strobes);
    chk("crc_field", fld, 32'h0);
    chk("crc_value", 32'(crc_out), 32'(crc_gold(8'h00)));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
